// File: rtl/i2c_slave_burst_fsm.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_burst_fsm
// Brief    : I2C slave protocol engine with multi-byte bursts, repeated START,
//            STOP anywhere and bounded write bursts. Optional macro
//            I2C_SLV_GCALL_EN adds general-call (8'h00) address matching.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_burst_fsm #(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             rx_edge,
    input  logic             tx_edge,
    input  logic             scl_in,
    input  logic             sda_in,
    input  logic [6:0]       own_addr,
    input  logic             rx_full,
    input  logic             tx_valid,
    input  logic [7:0]       tx_data,
    output logic             sda_oe,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             tx_pop,
    output logic             tx_underrun,
    output logic             stop_det,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             busy,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_AACK  = 3'd2,
        S_TXD   = 3'd3,
        S_TXACK = 3'd4,
        S_RXD   = 3'd5,
        S_RXACK = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] C_CNT_LIM = CNT_W'(MAX_BURST - 1);

    state_t           r_state,      w_state;
    logic [7:0]       r_shreg,      w_shreg;
    logic [3:0]       r_bit_cnt,    w_bit_cnt;
    logic [CNT_W-1:0] r_byte_cnt,   w_byte_cnt;
    logic             r_rw,         w_rw;
    logic             r_mack,       w_mack;
    logic             r_ack,        w_ack;
    logic             r_sda_oe,     w_sda_oe;
    logic [7:0]       r_rx_data,    w_rx_data;
    logic             r_rx_valid,   w_rx_valid;
    logic             r_tx_pop,     w_tx_pop;
    logic             r_tx_underrun, w_tx_underrun;
    logic             r_stop_det,   w_stop_det;
    logic             r_busy;
    logic             r_sda_prev;

    logic             w_start;
    logic             w_stop;
    logic             w_rx;
    logic             w_match;
    logic [7:0]       w_load;
    logic [7:0]       w_shift_in;
    logic [7:0]       w_shift_out;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_start     = scl_in &  r_sda_prev & ~sda_in;
    assign w_stop      = scl_in & ~r_sda_prev &  sda_in;
    // A coincident tx_edge wins; rx_edge is dropped in that cycle.
    assign w_rx        = rx_edge & ~tx_edge;
    assign w_load      = tx_valid ? tx_data : 8'hFF;
    assign w_shift_in  = {r_shreg[6:0], sda_in};
    assign w_shift_out = {r_shreg[6:0], 1'b0};
    assign w_cnt_inc   = (r_byte_cnt == C_CNT_MAX) ? r_byte_cnt : r_byte_cnt + CNT_W'(1);

`ifdef I2C_SLV_GCALL_EN
    assign w_match = (r_shreg[7:1] == own_addr) || (r_shreg == 8'h00);
`else
    assign w_match = (r_shreg[7:1] == own_addr);
`endif

    always_comb begin
        w_state       = r_state;
        w_shreg       = r_shreg;
        w_bit_cnt     = r_bit_cnt;
        w_byte_cnt    = r_byte_cnt;
        w_rw          = r_rw;
        w_mack        = r_mack;
        w_ack         = r_ack;
        w_sda_oe      = r_sda_oe;
        w_rx_data     = r_rx_data;
        w_rx_valid    = 1'b0;
        w_tx_pop      = 1'b0;
        w_tx_underrun = 1'b0;
        w_stop_det    = 1'b0;

        if (w_start) begin
            w_state    = S_ADDR;
            w_bit_cnt  = 4'd0;
            w_byte_cnt = '0;
            w_sda_oe   = 1'b0;
        end else if (w_stop) begin
            w_byte_cnt = '0;
            if (r_state != S_IDLE) begin
                w_state    = S_IDLE;
                w_sda_oe   = 1'b0;
                w_stop_det = 1'b1;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_sda_oe = 1'b0;
                end
                S_ADDR: begin
                    if (tx_edge) begin
                        if (r_bit_cnt == 4'd8) begin
                            if (w_match) begin
                                w_state  = S_AACK;
                                w_rw     = r_shreg[0];
                                w_sda_oe = 1'b1;
                            end else begin
                                w_state  = S_IDLE;
                                w_sda_oe = 1'b0;
                            end
                        end
                    end else if (w_rx && r_bit_cnt != 4'd8) begin
                        w_shreg   = w_shift_in;
                        w_bit_cnt = r_bit_cnt + 4'd1;
                    end
                end
                S_AACK: begin
                    w_sda_oe = 1'b1;
                    if (tx_edge) begin
                        w_bit_cnt = 4'd0;
                        if (r_rw) begin
                            w_state       = S_TXD;
                            w_shreg       = w_load;
                            w_sda_oe      = ~w_load[7];
                            w_tx_pop      = tx_valid;
                            w_tx_underrun = ~tx_valid;
                        end else begin
                            w_state  = S_RXD;
                            w_sda_oe = 1'b0;
                        end
                    end
                end
                S_TXD: begin
                    if (tx_edge) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_state  = S_TXACK;
                            w_sda_oe = 1'b0;
                            w_mack   = 1'b1;
                        end else begin
                            w_shreg  = w_shift_out;
                            w_sda_oe = ~w_shift_out[7];
                        end
                    end else if (w_rx && r_bit_cnt != 4'd8) begin
                        w_bit_cnt = r_bit_cnt + 4'd1;
                    end
                end
                S_TXACK: begin
                    w_sda_oe = 1'b0;
                    if (tx_edge) begin
                        if (!r_mack) begin
                            w_state       = S_TXD;
                            w_byte_cnt    = w_cnt_inc;
                            w_bit_cnt     = 4'd0;
                            w_shreg       = w_load;
                            w_sda_oe      = ~w_load[7];
                            w_tx_pop      = tx_valid;
                            w_tx_underrun = ~tx_valid;
                        end else begin
                            w_state = S_IDLE;
                        end
                    end else if (w_rx) begin
                        w_mack = sda_in;
                    end
                end
                S_RXD: begin
                    if (tx_edge) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_state = S_RXACK;
                            // Last slot of the burst is refused so the master sees the limit.
                            if (!rx_full && (r_byte_cnt < C_CNT_LIM)) begin
                                w_ack      = 1'b1;
                                w_sda_oe   = 1'b1;
                                w_byte_cnt = w_cnt_inc;
                            end else begin
                                w_ack    = 1'b0;
                                w_sda_oe = 1'b0;
                            end
                        end
                    end else if (w_rx && r_bit_cnt != 4'd8) begin
                        w_shreg   = w_shift_in;
                        w_bit_cnt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_rx_data  = w_shift_in;
                            w_rx_valid = 1'b1;
                        end
                    end
                end
                S_RXACK: begin
                    if (tx_edge) begin
                        w_sda_oe  = 1'b0;
                        w_bit_cnt = 4'd0;
                        w_state   = r_ack ? S_RXD : S_IDLE;
                    end
                end
                default: begin
                    w_state  = S_IDLE;
                    w_sda_oe = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state       <= S_IDLE;
            r_shreg       <= 8'h00;
            r_bit_cnt     <= 4'd0;
            r_byte_cnt    <= '0;
            r_rw          <= 1'b0;
            r_mack        <= 1'b1;
            r_ack         <= 1'b0;
            r_sda_oe      <= 1'b0;
            r_rx_data     <= 8'h00;
            r_rx_valid    <= 1'b0;
            r_tx_pop      <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_stop_det    <= 1'b0;
            r_busy        <= 1'b0;
            r_sda_prev    <= 1'b1;
        end else begin
            r_state       <= w_state;
            r_shreg       <= w_shreg;
            r_bit_cnt     <= w_bit_cnt;
            r_byte_cnt    <= w_byte_cnt;
            r_rw          <= w_rw;
            r_mack        <= w_mack;
            r_ack         <= w_ack;
            r_sda_oe      <= w_sda_oe;
            r_rx_data     <= w_rx_data;
            r_rx_valid    <= w_rx_valid;
            r_tx_pop      <= w_tx_pop;
            r_tx_underrun <= w_tx_underrun;
            r_stop_det    <= w_stop_det;
            r_busy        <= (w_state != S_IDLE);
            r_sda_prev    <= sda_in;
        end
    end

    assign sda_oe      = r_sda_oe;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_pop      = r_tx_pop;
    assign tx_underrun = r_tx_underrun;
    assign stop_det    = r_stop_det;
    assign byte_cnt    = r_byte_cnt;
    assign busy        = r_busy;
    assign state       = r_state;

endmodule
`default_nettype wire
